// File: rtl/ps2_key_ctrl.sv
// Drains the ps2_keyboard FIFO and folds E0/F0 prefixes into single key events,
// tracking the held key, a press counter and a sticky overflow flag.
module ps2_key_ctrl #(
    parameter int CNT_W     = 8,
    parameter bit REPEAT_EN = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic             ready,
    input  logic [7:0]       data,
    input  logic             overflow,
    output logic             nextdata_n,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_break,
    output logic             key_repeat,
    output logic             key_down,
    output logic [7:0]       held_code,
    output logic             held_ext,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_sticky,
    input  logic             clr_ovf,
    output logic             err,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_DEC  = 2'd2
    } state_t;

    state_t           state_q;
    logic [7:0]       byte_q;
    logic             nextdata_n_q;
    logic             ext_pend_q;
    logic             brk_pend_q;
    logic             key_valid_q;
    logic [7:0]       key_code_q;
    logic             key_ext_q;
    logic             key_break_q;
    logic             key_repeat_q;
    logic             key_down_q;
    logic [7:0]       held_code_q;
    logic             held_ext_q;
    logic [CNT_W-1:0] press_cnt_q;
    logic [CNT_W-1:0] press_cnt_d;
    logic             ovf_sticky_q;
    logic             err_q;
    logic             is_bad_s;
    logic             held_match_s;

    assign press_cnt_d  = press_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign is_bad_s     = (byte_q == 8'h00) || (byte_q == 8'hFF) ||
                          (byte_q == 8'hAA) || (byte_q == 8'hFC);
    assign held_match_s = key_down_q && (held_code_q == byte_q) &&
                          (held_ext_q == ext_pend_q);

    // Handshake FSM, prefix parser, held-key tracking and overflow latch
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            byte_q       <= 8'h00;
            nextdata_n_q <= 1'b1;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            key_valid_q  <= 1'b0;
            key_code_q   <= 8'h00;
            key_ext_q    <= 1'b0;
            key_break_q  <= 1'b0;
            key_repeat_q <= 1'b0;
            key_down_q   <= 1'b0;
            held_code_q  <= 8'h00;
            held_ext_q   <= 1'b0;
            press_cnt_q  <= '0;
            ovf_sticky_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
            // Set has priority over clear
            if (overflow) begin
                ovf_sticky_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_sticky_q <= 1'b0;
            end else begin
                ovf_sticky_q <= ovf_sticky_q;
            end

            case (state_q)
                S_IDLE: begin
                    if (en && ready) begin
                        byte_q       <= data;
                        nextdata_n_q <= 1'b0;
                        state_q      <= S_POP;
                    end else begin
                        nextdata_n_q <= 1'b1;
                    end
                end
                // Gap cycle: the FIFO head advances while we wait here
                S_POP: begin
                    nextdata_n_q <= 1'b1;
                    state_q      <= S_DEC;
                end
                S_DEC: begin
                    state_q <= S_IDLE;
                    if (byte_q == 8'hE0) begin
                        ext_pend_q <= 1'b1;
                    end else if (byte_q == 8'hF0) begin
                        brk_pend_q <= 1'b1;
                    end else if (is_bad_s) begin
                        err_q      <= 1'b1;
                        ext_pend_q <= 1'b0;
                        brk_pend_q <= 1'b0;
                    end else begin
                        ext_pend_q <= 1'b0;
                        brk_pend_q <= 1'b0;
                        if (brk_pend_q) begin
                            key_valid_q  <= 1'b1;
                            key_code_q   <= byte_q;
                            key_ext_q    <= ext_pend_q;
                            key_break_q  <= 1'b1;
                            key_repeat_q <= 1'b0;
                            if (held_match_s) begin
                                key_down_q <= 1'b0;
                            end else begin
                                key_down_q <= key_down_q;
                            end
                        end else if (held_match_s) begin
                            // Typematic repeat never counts as a new press
                            if (REPEAT_EN) begin
                                key_valid_q  <= 1'b1;
                                key_code_q   <= byte_q;
                                key_ext_q    <= ext_pend_q;
                                key_break_q  <= 1'b0;
                                key_repeat_q <= 1'b1;
                            end else begin
                                key_valid_q  <= 1'b0;
                            end
                        end else begin
                            key_valid_q  <= 1'b1;
                            key_code_q   <= byte_q;
                            key_ext_q    <= ext_pend_q;
                            key_break_q  <= 1'b0;
                            key_repeat_q <= 1'b0;
                            key_down_q   <= 1'b1;
                            held_code_q  <= byte_q;
                            held_ext_q   <= ext_pend_q;
                            press_cnt_q  <= press_cnt_d;
                        end
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    nextdata_n_q <= 1'b1;
                end
            endcase
        end
    end

    assign nextdata_n = nextdata_n_q;
    assign key_valid  = key_valid_q;
    assign key_code   = key_code_q;
    assign key_ext    = key_ext_q;
    assign key_break  = key_break_q;
    assign key_repeat = key_repeat_q;
    assign key_down   = key_down_q;
    assign held_code  = held_code_q;
    assign held_ext   = held_ext_q;
    assign press_cnt  = press_cnt_q;
    assign ovf_sticky = ovf_sticky_q;
    assign err        = err_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: a queue models the ps2_keyboard FIFO, and a
// second instance with REPEAT_EN=1 shares all inputs to observe repeat events.
module tb_ps2_key_ctrl;

    logic       clk = 1'b0;
    logic       resetn, en, ready, overflow, clr_ovf;
    logic [7:0] data;

    logic       nextdata_n, key_valid, key_ext, key_break, key_repeat, key_down;
    logic       held_ext, ovf_sticky, err, busy;
    logic [7:0] key_code, held_code, press_cnt;

    logic       r_nextdata_n, r_key_valid, r_key_ext, r_key_break, r_key_repeat;
    logic       r_key_down, r_held_ext, r_ovf_sticky, r_err, r_busy;
    logic [7:0] r_key_code, r_held_code, r_press_cnt;

    ps2_key_ctrl #(.CNT_W(8), .REPEAT_EN(1'b0)) dut (
        .clk(clk), .resetn(resetn), .en(en), .ready(ready), .data(data),
        .overflow(overflow), .nextdata_n(nextdata_n), .key_valid(key_valid),
        .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
        .key_repeat(key_repeat), .key_down(key_down), .held_code(held_code),
        .held_ext(held_ext), .press_cnt(press_cnt), .ovf_sticky(ovf_sticky),
        .clr_ovf(clr_ovf), .err(err), .busy(busy)
    );

    ps2_key_ctrl #(.CNT_W(8), .REPEAT_EN(1'b1)) dut_rep (
        .clk(clk), .resetn(resetn), .en(en), .ready(ready), .data(data),
        .overflow(overflow), .nextdata_n(r_nextdata_n), .key_valid(r_key_valid),
        .key_code(r_key_code), .key_ext(r_key_ext), .key_break(r_key_break),
        .key_repeat(r_key_repeat), .key_down(r_key_down), .held_code(r_held_code),
        .held_ext(r_held_ext), .press_cnt(r_press_cnt), .ovf_sticky(r_ovf_sticky),
        .clr_ovf(clr_ovf), .err(r_err), .busy(r_busy)
    );

    always #5 clk = ~clk;

    logic [7:0]  fifo[$];
    logic [10:0] ev[$];      // {ext, break, repeat, code}
    logic [10:0] ev_rep[$];
    int          pop_t[$];
    int          cyc = 0;
    int          nd_low = 0;
    int          err_cnt = 0;
    int          total = 0;
    int          passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic upd_fifo_pins();
        ready = (fifo.size() != 0);
        data  = ready ? fifo[0] : 8'h00;
    endtask

    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        upd_fifo_pins();
    endtask

    // One clock: sample 1 time unit after the edge, then act as the FIFO
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (!nextdata_n) begin
            nd_low++;
            pop_t.push_back(cyc);
            if (fifo.size() != 0) void'(fifo.pop_front());
        end
        upd_fifo_pins();
        if (key_valid)   ev.push_back({key_ext, key_break, key_repeat, key_code});
        if (r_key_valid) ev_rep.push_back({r_key_ext, r_key_break, r_key_repeat, r_key_code});
        if (err) err_cnt++;
    endtask

    task automatic clear_logs();
        ev.delete();
        ev_rep.delete();
        pop_t.delete();
        nd_low  = 0;
        err_cnt = 0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((fifo.size() != 0 || busy) && n < 4000) begin
            step();
            n++;
        end
        step();
        step();
        chk(tag, {31'd0, (fifo.size() == 0 && !busy)}, 32'd1);
    endtask

    initial begin
        resetn = 1'b0; en = 1'b1; overflow = 1'b0; clr_ovf = 1'b0;
        ready = 1'b0; data = 8'h00;
        step();
        step();
        chk("rst_nextdata_n", nextdata_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_outs", {key_valid, key_code, key_ext, key_break, key_repeat, key_down,
                         held_code, held_ext, press_cnt, ovf_sticky, err}, 0);
        resetn = 1'b1;
        step();
        clear_logs();

        // Single make
        push(8'h15);
        drain("drain_make");
        chk("make_nd_low", nd_low, 1);
        chk("make_evcnt", ev.size(), 1);
        if (ev.size() > 0) chk("make_ev", ev[0], {3'b000, 8'h15});
        chk("make_held", {key_down, held_ext, held_code}, {2'b10, 8'h15});
        chk("make_cnt", press_cnt, 1);

        // Break of the held key
        clear_logs();
        push(8'hF0); push(8'h15);
        drain("drain_break");
        chk("brk_evcnt", ev.size(), 1);
        if (ev.size() > 0) chk("brk_ev", ev[0], {3'b010, 8'h15});
        chk("brk_down", key_down, 0);
        chk("brk_cnt", press_cnt, 1);

        // Extended make then extended break
        clear_logs();
        push(8'hE0); push(8'h75);
        drain("drain_emake");
        chk("emake_evcnt", ev.size(), 1);
        if (ev.size() > 0) chk("emake_ev", ev[0], {3'b100, 8'h75});
        chk("emake_held", {key_down, held_ext, held_code}, {2'b11, 8'h75});
        clear_logs();
        push(8'hE0); push(8'hF0); push(8'h75);
        drain("drain_ebrk");
        chk("ebrk_evcnt", ev.size(), 1);
        if (ev.size() > 0) chk("ebrk_ev", ev[0], {3'b110, 8'h75});
        chk("ebrk_down", key_down, 0);
        chk("ebrk_cnt", press_cnt, 2);

        // Typematic repeat: suppressed vs emitted
        clear_logs();
        push(8'h15); push(8'h15); push(8'h15);
        drain("drain_rep");
        chk("rep0_evcnt", ev.size(), 1);
        chk("rep0_cnt", press_cnt, 3);
        chk("rep1_evcnt", ev_rep.size(), 3);
        if (ev_rep.size() == 3) begin
            chk("rep1_ev0", ev_rep[0], {3'b000, 8'h15});
            chk("rep1_ev1", ev_rep[1], {3'b001, 8'h15});
            chk("rep1_ev2", ev_rep[2], {3'b001, 8'h15});
        end
        chk("rep1_cnt", r_press_cnt, 3);

        // Error byte after a break prefix
        clear_logs();
        push(8'hF0); push(8'h00); push(8'h23);
        drain("drain_err");
        chk("err_cnt", err_cnt, 1);
        chk("err_evcnt", ev.size(), 1);
        if (ev.size() > 0) chk("err_ev", ev[0], {3'b000, 8'h23});
        chk("err_held", {key_down, held_code}, {1'b1, 8'h23});
        chk("err_cnt_press", press_cnt, 4);

        // Hold off with en=0, then pops every 3 cycles
        clear_logs();
        en = 1'b0;
        push(8'h1C); push(8'hF0); push(8'h1C); push(8'h32);
        repeat (6) step();
        chk("hold_nd_low", nd_low, 0);
        chk("hold_fifo", fifo.size(), 4);
        en = 1'b1;
        drain("drain_en");
        chk("en_pops", pop_t.size(), 4);
        if (pop_t.size() == 4) begin
            chk("en_gap1", pop_t[1] - pop_t[0], 3);
            chk("en_gap2", pop_t[2] - pop_t[1], 3);
            chk("en_gap3", pop_t[3] - pop_t[2], 3);
        end
        chk("en_evcnt", ev.size(), 3);
        chk("en_held", {key_down, held_code}, {1'b1, 8'h32});
        chk("en_cnt", press_cnt, 6);

        // Overflow latch: set beats clear, then clear alone
        overflow = 1'b1; clr_ovf = 1'b1;
        step();
        chk("ovf_setwins", ovf_sticky, 1);
        overflow = 1'b0;
        step();
        chk("ovf_clear", ovf_sticky, 0);
        clr_ovf = 1'b0;

        // Reset while in S_POP
        clear_logs();
        push(8'h15);
        begin
            int n = 0;
            while (nextdata_n && n < 20) begin
                step();
                n++;
            end
        end
        chk("rstpop_reached", {nextdata_n, busy}, 2'b01);
        resetn = 1'b0;
        step();
        chk("rstpop_nd", nextdata_n, 1);
        chk("rstpop_busy", busy, 0);
        chk("rstpop_outs", {key_valid, key_code, key_ext, key_break, key_repeat, key_down,
                            held_code, held_ext, press_cnt, ovf_sticky, err}, 0);
        resetn = 1'b1;
        step();

        // 256 make/break pairs wrap the counter
        clear_logs();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] c;
            c = 8'h01 + 8'(i % 64);
            push(c); push(8'hF0); push(c);
        end
        drain("drain_wrap");
        chk("wrap_evcnt", ev.size(), 512);
        chk("wrap_cnt", press_cnt, 0);
        chk("wrap_down", key_down, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
